// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the instruction-fetch
// port and the load/store port. One transaction is in flight at a time.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_data,
    output logic                ram_en,
    output logic                ram_wen,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_wmask,
    input  logic [DATA_W-1:0]   ram_rdata
);
    localparam int MASK_W = DATA_W / 8;
    localparam logic [2:0] LAT = 3'(RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;        // 0 = IF, 1 = LS
    logic                last_ls_q, last_ls_d;    // last grant went to LS
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [DATA_W-1:0]   ls_data_q, ls_data_d;

    logic grant_if;
    logic grant_ls;

    // On a tie the port that did not win last time is granted.
    assign grant_if = if_req_valid & (~ls_req_valid | last_ls_q);
    assign grant_ls = ls_req_valid & (~if_req_valid | ~last_ls_q);

    // Readies are gated by rst so they read 0 while reset is held.
    assign if_req_ready = rst & (state_q == S_IDLE) & grant_if;
    assign ls_req_ready = rst & (state_q == S_IDLE) & grant_ls;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_ls_d = last_ls_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        cnt_d     = cnt_q;
        if_data_d = if_data_q;
        ls_data_d = ls_data_q;
        case (state_q)
            S_IDLE: begin
                if (if_req_valid && if_req_ready) begin
                    owner_d   = 1'b0;
                    addr_d    = if_addr;
                    wen_d     = 1'b0;
                    wmask_d   = '0;
                    last_ls_d = 1'b0;
                    state_d   = S_ISSUE;
                end else if (ls_req_valid && ls_req_ready) begin
                    owner_d   = 1'b1;
                    addr_d    = ls_addr;
                    wen_d     = ls_wen;
                    wdata_d   = ls_wdata;
                    wmask_d   = ls_wmask;
                    last_ls_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wen_q) begin
                    ls_data_d = '0;
                    state_d   = S_RESP;
                end else begin
                    cnt_d   = 3'd1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == LAT) begin
                    if (owner_q) begin
                        ls_data_d = ram_rdata;
                    end else begin
                        if_data_d = ram_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            last_ls_q <= 1'b1;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            cnt_q     <= '0;
            if_data_q <= '0;
            ls_data_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_ls_q <= last_ls_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            cnt_q     <= cnt_d;
            if_data_q <= if_data_d;
            ls_data_q <= ls_data_d;
        end
    end

    assign ram_en       = (state_q == S_ISSUE);
    assign ram_wen      = ram_en & wen_q;
    assign ram_wmask    = ram_en ? wmask_q : '0;
    assign ram_addr     = addr_q & ~ADDR_W'(3);
    assign ram_wdata    = wdata_q;
    assign if_rsp_valid = (state_q == S_RESP) & ~owner_q;
    assign ls_rsp_valid = (state_q == S_RESP) & owner_q;
    assign if_rsp_data  = if_data_q;
    assign ls_rsp_data  = ls_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RD_LAT=1, one with RD_LAT=3,
// each backed by a small behavioural RAM that only drives valid data on the right cycle.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // RD_LAT = 1 instance signals
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_addr, if_rsp_data;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
    logic [31:0] ls_addr, ls_wdata, ls_rsp_data;
    logic [3:0]  ls_wmask;
    logic        ram_en, ram_wen;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_wmask;

    // RD_LAT = 3 instance signals
    logic        if_req_valid3, if_req_ready3, if_rsp_valid3;
    logic [31:0] if_addr3, if_rsp_data3;
    logic        ls_req_valid3, ls_req_ready3, ls_wen3, ls_rsp_valid3;
    logic [31:0] ls_addr3, ls_wdata3, ls_rsp_data3;
    logic [3:0]  ls_wmask3;
    logic        ram_en3, ram_wen3;
    logic [31:0] ram_addr3, ram_wdata3, ram_rdata3;
    logic [3:0]  ram_wmask3;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid3), .if_req_ready(if_req_ready3), .if_addr(if_addr3),
        .if_rsp_valid(if_rsp_valid3), .if_rsp_data(if_rsp_data3),
        .ls_req_valid(ls_req_valid3), .ls_req_ready(ls_req_ready3), .ls_addr(ls_addr3),
        .ls_wen(ls_wen3), .ls_wdata(ls_wdata3), .ls_wmask(ls_wmask3),
        .ls_rsp_valid(ls_rsp_valid3), .ls_rsp_data(ls_rsp_data3),
        .ram_en(ram_en3), .ram_wen(ram_wen3), .ram_addr(ram_addr3),
        .ram_wdata(ram_wdata3), .ram_wmask(ram_wmask3), .ram_rdata(ram_rdata3)
    );

    // RAM model, latency 1: data valid only in the cycle after ram_en, junk otherwise.
    logic [31:0] mem1 [256];
    logic        rv1;
    logic [31:0] rd1;
    always @(posedge clk) begin
        if (!rst) begin
            mem1[1]  <= 32'h00A0_0093;
            mem1[2]  <= 32'h1111_2222;
            mem1[64] <= 32'h1234_5678;
            rv1      <= 1'b0;
        end else begin
            rv1 <= ram_en && !ram_wen;
            rd1 <= mem1[ram_addr[9:2]];
            if (ram_en && ram_wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wmask[b]) mem1[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end
    assign ram_rdata = rv1 ? rd1 : 32'hBAD0_0001;

    // RAM model, latency 3.
    logic [31:0] mem3 [256];
    logic [2:0]  rv3;
    logic [31:0] rd3 [3];
    always @(posedge clk) begin
        if (!rst) begin
            mem3[1] <= 32'hCAFE_F00D;
            mem3[2] <= 32'h5566_7788;
            rv3     <= 3'b000;
        end else begin
            rv3    <= {rv3[1:0], ram_en3 && !ram_wen3};
            rd3[0] <= mem3[ram_addr3[9:2]];
            rd3[1] <= rd3[0];
            rd3[2] <= rd3[1];
        end
    end
    assign ram_rdata3 = rv3[2] ? rd3[2] : 32'hBAD0_0003;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_exp [16];
    logic [4:0] l3_exp [12];

    initial begin
        rr_exp = '{4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0001,
                   4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0001};
        l3_exp = '{5'b10000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00010,
                   5'b01000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00001};

        if_req_valid = 1'b1; if_addr = 32'h8000_0004;
        ls_req_valid = 1'b1; ls_addr = 32'h8000_0008; ls_wen = 1'b0;
        ls_wdata = '0; ls_wmask = '0;
        if_req_valid3 = 1'b0; if_addr3 = '0;
        ls_req_valid3 = 1'b0; ls_addr3 = '0; ls_wen3 = 1'b0; ls_wdata3 = '0; ls_wmask3 = '0;

        // Reset held with both requesters valid
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_if_ready", if_req_ready, 0);
        check("rst_ls_ready", ls_req_ready, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_wen", ram_wen, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_ram_wmask", ram_wmask, 0);
        check("rst_if_rsp", {if_rsp_valid, if_rsp_data}, 0);
        check("rst_ls_rsp", {ls_rsp_valid, ls_rsp_data}, 0);
        $display("reset state checked");

        // Round robin: both valid continuously, grants IF, LS, IF, LS
        next_cycle();
        rst = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if_req_valid = (c <= 12);
            ls_req_valid = (c <= 12);
            @(negedge clk);
            check($sformatf("rr_c%0d", c),
                  {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid}, rr_exp[c]);
            if (c == 3 || c == 11) check($sformatf("rr_if_data_c%0d", c), if_rsp_data, 32'h00A0_0093);
            if (c == 7 || c == 15) check($sformatf("rr_ls_data_c%0d", c), ls_rsp_data, 32'h1111_2222);
            if (rr_exp[c][3] || rr_exp[c][2]) $display("rr cycle %0d grant if=%0d ls=%0d", c, if_req_ready, ls_req_ready);
            next_cycle();
        end

        // IF read of unaligned address
        if_req_valid = 1'b1; if_addr = 32'h8000_0006;
        @(negedge clk);
        check("ifrd_ready", if_req_ready, 1);
        next_cycle();
        if_req_valid = 1'b0;
        @(negedge clk);
        check("ifrd_issue", {ram_en, ram_wen, ram_addr}, {1'b1, 1'b0, 32'h8000_0004});
        next_cycle();
        @(negedge clk);
        check("ifrd_c2_rsp", if_rsp_valid, 0);
        next_cycle();
        @(negedge clk);
        check("ifrd_c3_rsp", {if_rsp_valid, if_rsp_data}, {1'b1, 32'h00A0_0093});
        check("ifrd_c3_ls", ls_rsp_valid, 0);
        next_cycle();
        @(negedge clk);
        check("ifrd_c4_rsp", if_rsp_valid, 0);
        $display("if read 0x80000006 -> %h", if_rsp_data);
        next_cycle();

        // LS partial write
        ls_req_valid = 1'b1; ls_wen = 1'b1; ls_addr = 32'h8000_0100;
        ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'b0011;
        @(negedge clk);
        check("lswr_ready", {if_req_ready, ls_req_ready}, 2'b01);
        next_cycle();
        ls_req_valid = 1'b0;
        @(negedge clk);
        check("lswr_issue", {ram_en, ram_wen, ram_addr, ram_wdata, ram_wmask},
              {1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011});
        next_cycle();
        @(negedge clk);
        check("lswr_ack", {ls_rsp_valid, ls_rsp_data}, {1'b1, 32'h0});
        check("lswr_no_if", if_rsp_valid, 0);
        check("lswr_if_hold", if_rsp_data, 32'h00A0_0093);
        check("lswr_strobes_off", {ram_en, ram_wen, ram_wmask}, 0);
        $display("ls write 0x80000100 acked");
        next_cycle();

        // LS read back of the partially written word
        ls_req_valid = 1'b1; ls_wen = 1'b0;
        next_cycle();
        ls_req_valid = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("lsrd_back", {ls_rsp_valid, ls_rsp_data}, {1'b1, 32'h1234_BEEF});
        $display("ls read 0x80000100 -> %h", ls_rsp_data);
        next_cycle();

        // Reset asserted during WAIT of an IF read
        if_req_valid = 1'b1; if_addr = 32'h8000_0004;
        next_cycle();
        if_req_valid = 1'b0;
        next_cycle();
        if_req_valid = 1'b1; ls_req_valid = 1'b1; if_addr = 32'h8000_0008;
        rst = 1'b0;
        #1;
        check("abort_ready", {if_req_ready, ls_req_ready}, 2'b00);
        check("abort_if_data", {if_rsp_valid, if_rsp_data}, 0);
        check("abort_ls_data", ls_rsp_data, 0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("abort_no_rsp", {if_rsp_valid, ls_rsp_valid, ram_en}, 0);
        check("abort_tie_if", {if_req_ready, ls_req_ready}, 2'b10);
        next_cycle();
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("after_rst_rd", {if_rsp_valid, if_rsp_data}, {1'b1, 32'h1111_2222});
        $display("post-reset if read 0x80000008 -> %h", if_rsp_data);
        next_cycle();

        // RD_LAT=3: response at T+5, back-to-back accept at T+6, ram_en at T+7
        if_req_valid3 = 1'b1; if_addr3 = 32'h8000_0004;
        for (int c = 0; c < 12; c++) begin
            if (c == 1) begin
                if_req_valid3 = 1'b0;
                ls_req_valid3 = 1'b1; ls_addr3 = 32'h8000_0008;
            end
            if (c == 7) ls_req_valid3 = 1'b0;
            @(negedge clk);
            check($sformatf("lat3_c%0d", c),
                  {if_req_ready3, ls_req_ready3, ram_en3, if_rsp_valid3, ls_rsp_valid3}, l3_exp[c]);
            if (c == 5) check("lat3_if_data", if_rsp_data3, 32'hCAFE_F00D);
            if (c == 11) check("lat3_ls_data", ls_rsp_data3, 32'h5566_7788);
            next_cycle();
        end
        $display("lat3 reads -> %h %h", if_rsp_data3, ls_rsp_data3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
